// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-level interrupt controller, Wishbone slave, MTIP/MEIP drive.
// Define IRQ_CTRL_SYNC_EN to put a 2-flop synchroniser on irq_i.
module irq_ctrl #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0,
    parameter int          NUM_SOURCES  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stb_i,
    input  logic                   cyc_i,
    input  logic [31:0]            adr_i,
    input  logic [3:0]             sel_i,
    input  logic [31:0]            dat_i,
    output logic [31:0]            dat_o,
    input  logic                   we_i,
    output logic                   ack_o,
    output logic                   err_o,
    output logic                   rty_o,
    input  logic [NUM_SOURCES-1:0] irq_i,
    input  logic                   mtip_i,
    output logic                   mtip_o,
    output logic                   meip_o
);
    localparam int N = NUM_SOURCES;

    logic [N-1:0] irq_s;
    logic [N-1:0] irq_d;
    logic [N-1:0] pend_q;
    logic [N-1:0] en_q;
    logic [N-1:0] edge_q;
    logic [N-1:0] rise;
    logic [N-1:0] act;
    logic [N-1:0] clr;
    logic [N-1:0] bmask;
    logic [N-1:0] wdat;
    logic [N-1:0] claim_oh;
    logic [N-1:0] pend_nxt;
    logic [31:0]  bmask32;
    logic [31:0]  rd_q;
    logic [31:0]  rd_nxt;
    logic [31:0]  claim_val;
    logic [32:0]  diff;
    logic [1:0]   word;
    logic [4:0]   claim_idx;
    logic         addressed;
    logic         accept;
    logic         wr;
    logic         rd;
    logic         claim_hit;
    logic         unused_ok;

`ifdef IRQ_CTRL_SYNC_EN
    logic [N-1:0] sync_q;

    // two-flop synchroniser for asynchronous request lines
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            irq_s  <= '0;
        end else begin
            sync_q <= irq_i;
            irq_s  <= sync_q;
        end
    end
`else
    // single sampling flop; sources are already synchronous
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_s <= '0;
        end else begin
            irq_s <= irq_i;
        end
    end
`endif

    // borrow bit of the 33-bit subtract flags addresses below the base
    assign diff      = {1'b0, adr_i} - {1'b0, BASE_ADDRESS};
    assign addressed = ~diff[32] & (diff[31:4] == 28'd0);
    assign word      = diff[3:2];
    assign accept    = stb_i & cyc_i & ~ack_o & addressed;
    assign wr        = accept & we_i;
    assign rd        = accept & ~we_i;

    assign bmask32 = {{8{sel_i[3]}}, {8{sel_i[2]}},
                      {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign bmask   = bmask32[N-1:0];
    assign wdat    = dat_i[N-1:0] & bmask;
    assign rise    = irq_s & ~irq_d;
    assign act     = pend_q & en_q;

    // lowest active index wins the claim
    always_comb begin
        claim_hit = 1'b0;
        claim_idx = '0;
        claim_oh  = '0;
        for (int n = N - 1; n >= 0; n--) begin
            if (act[n]) begin
                claim_hit   = 1'b1;
                claim_idx   = 5'(n);
                claim_oh    = '0;
                claim_oh[n] = 1'b1;
            end
        end
        claim_val = claim_hit ? 32'(claim_idx) + 32'd1 : 32'd0;
    end

    // next pending: a fresh edge beats any clear in the same cycle
    always_comb begin
        clr = '0;
        if (wr && word == 2'd0) begin
            clr = clr | wdat;
        end
        if (rd && word == 2'd3) begin
            clr = clr | claim_oh;
        end
        pend_nxt = (edge_q & (rise | (pend_q & ~clr)))
                 | (~edge_q & irq_s);
    end

    // read mux over the four word registers
    always_comb begin
        rd_nxt = '0;
        unique case (word)
            2'd0: rd_nxt = 32'(pend_q);
            2'd1: rd_nxt = 32'(en_q);
            2'd2: rd_nxt = 32'(edge_q);
            2'd3: rd_nxt = claim_val;
        endcase
    end

    // bus handshake, read data capture and config register writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o  <= 1'b0;
            rd_q   <= '0;
            en_q   <= '0;
            edge_q <= '0;
        end else begin
            ack_o <= accept;
            if (accept) begin
                rd_q <= rd_nxt;
            end
            if (wr && word == 2'd1) begin
                en_q <= (en_q & ~bmask) | wdat;
            end
            if (wr && word == 2'd2) begin
                edge_q <= (edge_q & ~bmask) | wdat;
            end
        end
    end

    // pending latch and edge-detect history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
            irq_d  <= '0;
        end else begin
            pend_q <= pend_nxt;
            irq_d  <= irq_s;
        end
    end

    // registered interrupt lines towards the CPU
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meip_o <= 1'b0;
            mtip_o <= 1'b0;
        end else begin
            meip_o <= |act;
            mtip_o <= mtip_i;
        end
    end

    assign dat_o     = ack_o ? rd_q : 32'bz;
    assign err_o     = 1'b0;
    assign rty_o     = 1'b0;
    assign unused_ok = ^{diff[1:0], dat_i, bmask32};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus random stimulus against a behavioural model.
// Honors IRQ_CTRL_SYNC_EN for the sampling latency.
module tb_irq_ctrl;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int N = 8;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int SD = 1;
`else
    localparam int SD = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          stb_i;
    logic          cyc_i;
    logic          we_i;
    logic [31:0]   adr_i;
    logic [3:0]    sel_i;
    logic [31:0]   dat_i;
    logic [31:0]   dat_o;
    logic          ack_o;
    logic          err_o;
    logic          rty_o;
    logic [N-1:0]  irq_i;
    logic          mtip_i;
    logic          mtip_o;
    logic          meip_o;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_pend;
    logic [N-1:0] m_en;
    logic [N-1:0] m_edge;
    logic         m_ack;
    logic         m_wasrd;
    logic         m_meip;
    logic         m_mtip;
    logic [31:0]  m_rd;
    logic [N-1:0] hist[$];

    irq_ctrl #(.BASE_ADDRESS(BASE), .NUM_SOURCES(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .cyc_i(cyc_i),
        .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o),
        .irq_i(irq_i), .mtip_i(mtip_i), .mtip_o(mtip_o), .meip_o(meip_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // irq_i value seen k edges before the most recent sampled one
    function automatic logic [N-1:0] past(int k);
        int i;
        i = hist.size() - 1 - k;
        if (i < 0) return '0;
        return hist[i];
    endfunction

    // advance the reference model by one clock edge
    task automatic model_step();
        logic [N-1:0] s, d, np, ne, ned, clr;
        logic [31:0]  off, rdv;
        logic         acc;
        int           w, first;
        if (rst_i) begin
            m_pend = '0; m_en = '0; m_edge = '0;
            m_ack = 0; m_wasrd = 0; m_rd = '0;
            m_meip = 0; m_mtip = 0;
            hist.delete();
            return;
        end
        s = past(SD);
        d = past(SD + 1);
        off = adr_i - BASE;
        acc = stb_i && cyc_i && !m_ack && (adr_i >= BASE) && (off < 16);
        w = int'(off / 4);
        first = -1;
        for (int n = 0; n < N; n++)
            if (first < 0 && m_pend[n] && m_en[n]) first = n;
        clr = '0; ne = m_en; ned = m_edge; rdv = '0;
        if (acc) begin
            case (w)
                0: rdv = 32'(m_pend);
                1: rdv = 32'(m_en);
                2: rdv = 32'(m_edge);
                default: rdv = (first < 0) ? 0 : first + 1;
            endcase
            if (we_i) begin
                for (int n = 0; n < N; n++) begin
                    if (sel_i[n / 8]) begin
                        if (w == 0) clr[n] = dat_i[n];
                        if (w == 1) ne[n] = dat_i[n];
                        if (w == 2) ned[n] = dat_i[n];
                    end
                end
            end else if (w == 3 && first >= 0) begin
                clr[first] = 1'b1;
            end
        end
        for (int n = 0; n < N; n++)
            np[n] = m_edge[n] ? ((s[n] && !d[n]) || (m_pend[n] && !clr[n]))
                              : s[n];
        m_meip = |(m_pend & m_en);
        m_mtip = mtip_i;
        m_ack = acc;
        m_wasrd = acc && !we_i;
        if (acc) m_rd = rdv;
        m_pend = np; m_en = ne; m_edge = ned;
        hist.push_back(irq_i);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        chk("ack", ack_o, m_ack);
        chk("meip", meip_o, m_meip);
        chk("mtip", mtip_o, m_mtip);
        chk("err", err_o, 0);
        chk("rty", rty_o, 0);
        if (m_ack && m_wasrd) chk("rdata", dat_o, m_rd);
    endtask

    task automatic bus(input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat,
                       output logic [31:0] rdat);
        stb_i = 1; cyc_i = 1; we_i = we;
        adr_i = adr; sel_i = sel; dat_i = dat;
        tick();
        rdat = dat_o;
        chk("bus_ack", ack_o, 1);
        stb_i = 0; cyc_i = 0; we_i = 0;
        tick();
    endtask

    task automatic rdreg(input int w, output logic [31:0] v);
        bus(0, BASE + 32'(4 * w), 4'h0, 32'h0, v);
    endtask

    task automatic wrreg(input int w, input logic [31:0] v);
        logic [31:0] t;
        bus(1, BASE + 32'(4 * w), 4'hF, v, t);
    endtask

    initial begin
        logic [31:0] v;
        int cnt;
        rst_i = 1; stb_i = 0; cyc_i = 0; we_i = 0;
        adr_i = '0; sel_i = '0; dat_i = '0; irq_i = '0; mtip_i = 0;
        tick(); tick();
        rst_i = 0;
        tick();

        // reset state
        for (int w = 0; w < 4; w++) begin
            rdreg(w, v);
            chk("reset_reg", v, 0);
        end
        chk("reset_meip", meip_o, 0);
        chk("reset_mtip", mtip_o, 0);

        // edge source 0: latency, claim, clear
        wrreg(1, 32'h1);
        wrreg(2, 32'h1);
        irq_i = 8'h01;
        tick();
        irq_i = 8'h00;
        cnt = 0;
        while (meip_o !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("irq_lat", cnt, 2 + SD);
        rdreg(3, v);
        chk("claim_edge0", v, 32'h1);
        chk("meip_after_claim", meip_o, 0);
        rdreg(0, v);
        chk("pend_after_claim", v, 0);

        // level sources 2 and 3
        wrreg(2, 32'h0);
        wrreg(1, 32'h0C);
        irq_i = 8'h0C;
        repeat (4) tick();
        rdreg(3, v);
        chk("claim_lvl_a", v, 32'h3);
        rdreg(3, v);
        chk("claim_lvl_b", v, 32'h3);
        irq_i = 8'h08;
        repeat (4) tick();
        rdreg(3, v);
        chk("claim_lvl_c", v, 32'h4);
        wrreg(0, 32'h8);
        rdreg(0, v);
        chk("w1c_level", v, 32'h8);

        // edge source 1: set beats simultaneous W1C
        irq_i = 8'h00;
        wrreg(2, 32'h2);
        wrreg(1, 32'h2);
        repeat (4) tick();
        irq_i = 8'h02;
        tick();
        irq_i = 8'h00;
        repeat (4) tick();
        rdreg(0, v);
        chk("edge1_pend", v, 32'h2);
        irq_i = 8'h02;
        tick();
        irq_i = 8'h00;
        repeat (SD) tick();
        bus(1, BASE, 4'b0001, 32'h2, v);
        rdreg(0, v);
        chk("set_beats_w1c", v, 32'h2);
        bus(1, BASE, 4'b0010, 32'h2, v);
        rdreg(0, v);
        chk("w1c_wrong_byte", v, 32'h2);
        bus(1, BASE, 4'b0001, 32'h2, v);
        rdreg(0, v);
        chk("w1c_clear", v, 32'h0);

        // mtip passthrough, unmasked
        wrreg(1, 32'h0);
        mtip_i = 1;
        chk("mtip_pre", mtip_o, 0);
        tick();
        chk("mtip_rise", mtip_o, 1);
        mtip_i = 0;
        tick();
        chk("mtip_fall", mtip_o, 0);

        // unaddressed strobes
        wrreg(1, 32'h5A);
        stb_i = 1; cyc_i = 1; we_i = 1; sel_i = 4'hF; dat_i = 32'hFF;
        adr_i = BASE + 32'h10;
        tick();
        chk("unaddr_hi", ack_o, 0);
        adr_i = BASE - 32'h4;
        tick();
        chk("unaddr_lo", ack_o, 0);
        stb_i = 0; cyc_i = 0; we_i = 0;
        tick();
        rdreg(1, v);
        chk("unaddr_keep", v, 32'h5A);

        // reset in the middle of a transaction
        wrreg(1, 32'hFF);
        wrreg(2, 32'hFF);
        irq_i = 8'h10;
        tick();
        irq_i = 8'h00;
        repeat (4) tick();
        stb_i = 1; cyc_i = 1; we_i = 0; adr_i = BASE + 32'hC;
        tick();
        rst_i = 1; stb_i = 0; cyc_i = 0;
        tick();
        chk("rst_ack", ack_o, 0);
        rst_i = 0;
        tick();
        for (int w = 0; w < 4; w++) begin
            rdreg(w, v);
            chk("rst_reg", v, 0);
        end

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            int a;
            rst_i = ($urandom_range(0, 199) == 0);
            stb_i = $urandom_range(0, 1);
            cyc_i = ($urandom_range(0, 7) != 0);
            we_i = $urandom_range(0, 1);
            a = $urandom_range(0, 5);
            adr_i = (a == 5) ? BASE - 32'h4 : BASE + 32'(4 * a);
            sel_i = 4'($urandom);
            dat_i = $urandom;
            if ($urandom_range(0, 3) == 0) irq_i = N'($urandom);
            mtip_i = $urandom_range(0, 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
